// File: rtl/mips_defs.sv
// Shared definitions for the MEM-stage SRAM sequencer:
// bus widths, FSM state encoding and the byte-to-word address map.
package mips_defs;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // 32-bit word index relative to the SRAM window; wraps modulo 2^17
    function automatic logic [SRAM_AW-2:0] word_index(
        input logic [31:0] a,
        input logic [31:0] base
    );
        return (SRAM_AW-1)'((a - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle for the SRAM sequencer.
// The MEM stage is the master; the controller is the slave.
interface sram_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit async SRAM accesses,
// low half first, stalling the pipeline through ready until done.
module sram_controller
    import mips_defs::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   mem,
    output logic [SRAM_AW-1:0] SRAMaddress,
    output logic               SRAMWEn,
    output logic               SRAMOE,
    inout  wire  [SRAM_DW-1:0] SRAMdata
);

    state_t              state;
    logic [2:0]          cnt;
    logic [SRAM_AW-2:0]  waddr;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic                req;
    logic                last;
    logic                drive;
    logic [SRAM_DW-1:0]  dout;

    assign req  = mem.rd_en | mem.wr_en;
    assign last = (cnt == 3'(WAIT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            waddr <= '0;
            wdata <= '0;
            rdata <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        waddr <= word_index(mem.address, BASE_ADDR);
                        wdata <= mem.write_data;
                        // a store wins over a simultaneous load
                        state <= mem.wr_en ? S_WR_LO : S_RD_LO;
                    end
                end
                S_RD_LO: begin
                    cnt <= last ? 3'd0 : cnt + 3'd1;
                    if (last) begin
                        rdata[15:0] <= SRAMdata;
                        state       <= S_RD_HI;
                    end
                end
                S_RD_HI: begin
                    cnt <= last ? 3'd0 : cnt + 3'd1;
                    if (last) begin
                        rdata[31:16] <= SRAMdata;
                        state        <= S_DONE;
                    end
                end
                S_WR_LO: begin
                    cnt <= last ? 3'd0 : cnt + 3'd1;
                    if (last) state <= S_WR_HI;
                end
                S_WR_HI: begin
                    cnt <= last ? 3'd0 : cnt + 3'd1;
                    if (last) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // pins depend only on registered state, so they hold for a full phase
    always_comb begin
        SRAMWEn     = 1'b1;
        SRAMOE      = 1'b1;
        SRAMaddress = '0;
        drive       = 1'b0;
        dout        = '0;
        unique case (state)
            S_RD_LO: begin
                SRAMOE      = 1'b0;
                SRAMaddress = {waddr, 1'b0};
            end
            S_RD_HI: begin
                SRAMOE      = 1'b0;
                SRAMaddress = {waddr, 1'b1};
            end
            S_WR_LO: begin
                SRAMWEn     = 1'b0;
                SRAMaddress = {waddr, 1'b0};
                drive       = 1'b1;
                dout        = wdata[15:0];
            end
            S_WR_HI: begin
                SRAMWEn     = 1'b0;
                SRAMaddress = {waddr, 1'b1};
                drive       = 1'b1;
                dout        = wdata[31:16];
            end
            default: ;
        endcase
    end

    assign SRAMdata      = drive ? dout : 'z;
    assign mem.read_data = rdata;
    assign mem.ready     = (state == S_IDLE) ? ~req : (state == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench: two controllers (WAIT_CYCLES=1 and 0) against
// directed loads/stores with a bench-side SRAM read model.
module tb_sram_controller;

    typedef struct packed {
        logic [17:0] addr;
        logic        we_n;
        logic        oe_n;
        logic [15:0] data;
    } pin_t;

    typedef struct packed {
        logic [7:0]  frz;
        logic [31:0] rd;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   fails = 0;

    pin_t        pq[2][$];
    done_t       cq[2][$];
    logic [31:0] rd_model[2];

    sram_controller_if m0();
    sram_controller_if m1();

    logic [17:0] sa[2];
    logic        swe[2];
    logic        soe[2];
    logic        rdy[2];
    logic [31:0] srd[2];
    logic [15:0] sbus[2];
    wire  [17:0] a0, a1;
    wire         we0, we1, oe0, oe1;
    wire  [15:0] bus0, bus1;

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [17:0] a);
        return (a < 18'd2) ? 16'h0400 : (a[15:0] ^ 16'hC35A);
    endfunction

    assign bus0 = oe0 ? 16'bz : pat(a0);
    assign bus1 = oe1 ? 16'bz : pat(a1);

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .mem(m0),
        .SRAMaddress(a0), .SRAMWEn(we0), .SRAMOE(oe0), .SRAMdata(bus0)
    );

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .mem(m1),
        .SRAMaddress(a1), .SRAMWEn(we1), .SRAMOE(oe1), .SRAMdata(bus1)
    );

    assign sa[0] = a0;   assign sa[1] = a1;
    assign swe[0] = we0; assign swe[1] = we1;
    assign soe[0] = oe0; assign soe[1] = oe1;
    assign rdy[0] = m0.ready; assign rdy[1] = m1.ready;
    assign srd[0] = m0.read_data; assign srd[1] = m1.read_data;
    assign sbus[0] = bus0; assign sbus[1] = bus1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int k, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (k == 0) begin
            m0.rd_en = rd; m0.wr_en = wr; m0.address = a; m0.write_data = d;
        end else begin
            m1.rd_en = rd; m1.wr_en = wr; m1.address = a; m1.write_data = d;
        end
    endtask

    task automatic expect_txn(input int k, input logic wr,
                              input logic [31:0] a, input logic [31:0] d);
        int w = (k == 0) ? 1 : 0;
        logic [16:0] wi;
        pin_t p;
        done_t c;
        wi = 17'((a - 32'd1024) >> 2);
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i <= w; i++) begin
                p.addr = {wi, (h == 1)};
                p.we_n = !wr;
                p.oe_n = wr;
                p.data = (h == 1) ? d[31:16] : d[15:0];
                pq[k].push_back(p);
            end
        end
        if (!wr) rd_model[k] = {pat({wi, 1'b1}), pat({wi, 1'b0})};
        c.frz = 8'(2 * w + 3);
        c.rd  = rd_model[k];
        cq[k].push_back(c);
    endtask

    task automatic txn(input int k, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        expect_txn(k, wr, a, d);
        set_req(k, rd, wr, a, d);
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (rdy[k]) ok = 1'b1;
        end
        if (!ok) begin
            vectors++;
            fails++;
            $display("FAIL timeout: dut%0d ready never returned", k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        set_req(k, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int frz[2];
        bit busy[2];
        pin_t p;
        done_t c;
        frz = '{0, 0};
        busy = '{0, 0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!swe[k] || !soe[k]) begin
                    chk("we_oe_exclusive", 32'(swe[k] | soe[k]), 32'd1);
                    if (pq[k].size() == 0) begin
                        vectors++;
                        fails++;
                        $display("FAIL unexpected_access: dut%0d addr %h", k, sa[k]);
                    end else begin
                        p = pq[k].pop_front();
                        chk("sram_addr", 32'(sa[k]), 32'(p.addr));
                        chk("sram_we_n", 32'(swe[k]), 32'(p.we_n));
                        chk("sram_oe_n", 32'(soe[k]), 32'(p.oe_n));
                        if (!p.we_n) chk("sram_wdata", 32'(sbus[k]), 32'(p.data));
                    end
                end
                if (rst) begin
                    busy[k] = 1'b0;
                    frz[k] = 0;
                end else if (!rdy[k]) begin
                    busy[k] = 1'b1;
                    frz[k]++;
                end else if (busy[k]) begin
                    if (cq[k].size() == 0) begin
                        vectors++;
                        fails++;
                        $display("FAIL unexpected_done: dut%0d", k);
                    end else begin
                        c = cq[k].pop_front();
                        chk("frozen_cycles", 32'(frz[k]), 32'(c.frz));
                        chk("read_data", srd[k], c.rd);
                    end
                    busy[k] = 1'b0;
                    frz[k] = 0;
                end
            end
        end
    end

    initial begin
        rd_model = '{32'd0, 32'd0};
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_we_n", 32'(we0), 32'd1);
        chk("rst_oe_n", 32'(oe0), 32'd1);
        chk("rst_addr", 32'(a0), 32'd0);
        chk("rst_ready", 32'(m0.ready), 32'd1);
        chk("rst_read_data", m0.read_data, 32'd0);
        chk("rst_read_data1", m1.read_data, 32'd0);
        @(posedge clk);
        #1;

        txn(0, 1'b1, 1'b0, 32'd1024, 32'd0);
        idle(0);
        txn(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
        idle(0);
        txn(0, 1'b1, 1'b0, 32'd1100, 32'd0);
        idle(0);
        txn(0, 1'b1, 1'b1, 32'd1040, 32'h12345678);
        idle(0);
        txn(0, 1'b1, 1'b0, 32'd3, 32'd0);
        idle(0);
        txn(0, 1'b1, 1'b0, 32'd1088, 32'd0);
        txn(0, 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D);
        idle(0);

        // abort a load during its high-half phase
        pq[0].push_back('{18'd0, 1'b1, 1'b0, 16'd0});
        pq[0].push_back('{18'd0, 1'b1, 1'b0, 16'd0});
        pq[0].push_back('{18'd1, 1'b1, 1'b0, 16'd0});
        set_req(0, 1'b1, 1'b0, 32'd1024, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_oe_n", 32'(oe0), 32'd1);
        chk("abort_we_n", 32'(we0), 32'd1);
        chk("abort_ready", 32'(m0.ready), 32'd1);
        chk("abort_read_data", m0.read_data, 32'd0);
        rd_model = '{32'd0, 32'd0};
        @(posedge clk);
        #1;
        txn(0, 1'b1, 1'b0, 32'd1024, 32'd0);
        idle(0);

        txn(1, 1'b1, 1'b0, 32'd1100, 32'd0);
        txn(1, 1'b0, 1'b1, 32'd1032, 32'h0BADC0DE);
        txn(1, 1'b1, 1'b0, 32'd1024, 32'd0);
        idle(1);

        repeat (4) @(posedge clk);
        #1;
        chk("pin_q0_empty", 32'(pq[0].size()), 32'd0);
        chk("pin_q1_empty", 32'(pq[1].size()), 32'd0);
        chk("done_q0_empty", 32'(cq[0].size()), 32'd0);
        chk("done_q1_empty", 32'(cq[1].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
